// File: rtl/riscv_pkg.sv
// Shared front-end types: datapath width, redirect FSM states and the
// sequential next-PC helper used by branch resolution.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } redirect_state_e;

    // Fall-through PC; wraps modulo 2^XLEN past the top of the address space.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(3'd4);
    endfunction

endpackage

// File: rtl/branch_mispredict_check.sv
// Combinational branch/jump resolution: detects a wrong fetch-time prediction
// and produces the architecturally correct next PC.
module branch_mispredict_check
    import riscv_pkg::*;
(
    input  logic            i_ex_valid,
    input  logic            i_is_branch,
    input  logic            i_is_jump,
    input  logic            i_taken,
    input  logic [XLEN-1:0] i_target,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    output logic            o_resolve,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_correct_pc
);

    logic w_resolve;
    logic w_dir_wrong;
    logic w_tgt_wrong;

    // A taken outcome also needs the predicted target to match.
    always_comb begin
        w_resolve   = i_ex_valid & (i_is_branch | i_is_jump);
        w_dir_wrong = (i_taken != i_pred_taken);
        w_tgt_wrong = i_taken & (i_target != i_pred_target);
        o_resolve    = w_resolve;
        o_mispredict = w_resolve & (w_dir_wrong | w_tgt_wrong);
        if (i_taken) begin
            o_correct_pc = i_target;
        end else begin
            o_correct_pc = seq_pc(i_pc);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end recovery sequencer: holds a PC redirect until fetch accepts it,
// flushes wrong-path stages, and reports predictor updates and statistics.
module branch_redirect_ctrl
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            redirect_misaligned,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            bp_update_valid,
    output logic [XLEN-1:0] bp_update_pc,
    output logic [XLEN-1:0] bp_update_target,
    output logic            bp_update_taken,
    output logic [31:0]     resolve_count,
    output logic [31:0]     mispredict_count
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

    logic                   w_resolve;
    logic                   w_mispredict;
    logic [XLEN-1:0]        w_correct_pc;
    logic                   w_take_resolve;
    redirect_state_e        r_state;
    redirect_state_e        w_state_nxt;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic [DRAIN_CNT_W-1:0] w_drain_cnt_nxt;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_redirect_misaligned;
    logic                   r_flush;
    logic                   r_bp_valid;
    logic [XLEN-1:0]        r_bp_pc;
    logic [XLEN-1:0]        r_bp_target;
    logic                   r_bp_taken;
    logic [31:0]            r_resolve_cnt;
    logic [31:0]            r_mispredict_cnt;

    branch_mispredict_check u_check (
        .i_ex_valid    (ex_valid),
        .i_is_branch   (ex_is_branch),
        .i_is_jump     (ex_is_jump),
        .i_taken       (ex_taken),
        .i_target      (ex_target),
        .i_pc          (ex_pc),
        .i_pred_taken  (ex_pred_taken),
        .i_pred_target (ex_pred_target),
        .o_resolve     (w_resolve),
        .o_mispredict  (w_mispredict),
        .o_correct_pc  (w_correct_pc)
    );

    // Outcomes arriving outside IDLE belong to the wrong path and are dropped.
    assign w_take_resolve = w_resolve & (r_state == IDLE);

    // Next-state and drain-counter logic for the recovery FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            IDLE: begin
                if (w_mispredict) begin
                    w_state_nxt = REDIRECT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REDIRECT: begin
                if (!redirect_ready) begin
                    w_state_nxt = REDIRECT;
                end else if (DRAIN_INIT == {DRAIN_CNT_W{1'b0}}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt     = DRAIN;
                    w_drain_cnt_nxt = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (r_drain_cnt <= DRAIN_CNT_W'(1)) begin
                    w_state_nxt     = IDLE;
                    w_drain_cnt_nxt = {DRAIN_CNT_W{1'b0}};
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DRAIN_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_drain_cnt_nxt = {DRAIN_CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state plus redirect/flush outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state               <= IDLE;
            r_drain_cnt           <= {DRAIN_CNT_W{1'b0}};
            r_redirect_valid      <= 1'b0;
            r_redirect_pc         <= {XLEN{1'b0}};
            r_redirect_misaligned <= 1'b0;
            r_flush               <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_drain_cnt      <= w_drain_cnt_nxt;
            r_redirect_valid <= (w_state_nxt == REDIRECT);
            r_flush          <= (w_state_nxt != IDLE);
            if ((r_state == IDLE) && w_mispredict) begin
                r_redirect_pc         <= w_correct_pc;
                r_redirect_misaligned <= |w_correct_pc[1:0];
            end else if (w_state_nxt != REDIRECT) begin
                r_redirect_misaligned <= 1'b0;
            end
        end
    end

    // Predictor update pulse and wrapping resolution statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_valid       <= 1'b0;
            r_bp_pc          <= {XLEN{1'b0}};
            r_bp_target      <= {XLEN{1'b0}};
            r_bp_taken       <= 1'b0;
            r_resolve_cnt    <= 32'd0;
            r_mispredict_cnt <= 32'd0;
        end else begin
            r_bp_valid <= w_take_resolve;
            if (w_take_resolve) begin
                r_bp_pc       <= ex_pc;
                r_bp_target   <= ex_target;
                r_bp_taken    <= ex_taken;
                r_resolve_cnt <= r_resolve_cnt + 32'd1;
                if (w_mispredict) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
                end
            end
        end
    end

    assign redirect_valid      = r_redirect_valid;
    assign redirect_pc         = r_redirect_pc;
    assign redirect_misaligned = r_redirect_misaligned;
    assign flush_if_id         = r_flush;
    assign flush_id_ex         = r_flush;
    assign bp_update_valid     = r_bp_valid;
    assign bp_update_pc        = r_bp_pc;
    assign bp_update_target    = r_bp_target;
    assign bp_update_taken     = r_bp_taken;
    assign resolve_count       = r_resolve_cnt;
    assign mispredict_count    = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench: main instance built with DRAIN_CYCLES=2, a second with
// DRAIN_CYCLES=0 sharing the same stimulus.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_target, ex_pc, ex_pred_target;
    logic        redirect_ready;

    logic        redirect_valid, redirect_misaligned, flush_if_id, flush_id_ex;
    logic        bp_update_valid, bp_update_taken;
    logic [31:0] redirect_pc, bp_update_pc, bp_update_target;
    logic [31:0] resolve_count, mispredict_count;

    logic        d0_redirect_valid, d0_redirect_misaligned, d0_flush_if_id, d0_flush_id_ex;
    logic        d0_bp_update_valid, d0_bp_update_taken;
    logic [31:0] d0_redirect_pc, d0_bp_update_pc, d0_bp_update_target;
    logic [31:0] d0_resolve_count, d0_mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_misaligned(redirect_misaligned),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
        .bp_update_target(bp_update_target), .bp_update_taken(bp_update_taken),
        .resolve_count(resolve_count), .mispredict_count(mispredict_count)
    );

    branch_redirect_ctrl #(.DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_ready(redirect_ready), .redirect_valid(d0_redirect_valid),
        .redirect_pc(d0_redirect_pc), .redirect_misaligned(d0_redirect_misaligned),
        .flush_if_id(d0_flush_if_id), .flush_id_ex(d0_flush_id_ex),
        .bp_update_valid(d0_bp_update_valid), .bp_update_pc(d0_bp_update_pc),
        .bp_update_target(d0_bp_update_target), .bp_update_taken(d0_bp_update_taken),
        .resolve_count(d0_resolve_count), .mispredict_count(d0_mispredict_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pred_taken = 1'b0; ex_target = 32'h0; ex_pc = 32'h0; ex_pred_target = 32'h0;
    endtask

    task automatic drive(input logic br, input logic jmp, input logic tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1'b1; ex_is_branch = br; ex_is_jump = jmp; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    endtask

    task automatic do_reset();
        clear_ex();
        redirect_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_ex();
        redirect_ready = 1'b0;
        step();
        step();
        n_tests++;
        if ({redirect_valid, redirect_misaligned, flush_if_id, flush_id_ex, bp_update_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                {redirect_valid, redirect_misaligned, flush_if_id, flush_id_ex, bp_update_valid});
        end
        n_tests++;
        if (redirect_pc !== 32'h0 || resolve_count !== 32'h0 || mispredict_count !== 32'h0) begin
            n_fail++; $display("FAIL reset_regs: got pc=%h res=%0d mis=%0d expected 0/0/0",
                redirect_pc, resolve_count, mispredict_count);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mispredict();
        int flush_cycles;
        do_reset();
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 1'b0, 32'h0);
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h180) begin
            n_fail++; $display("FAIL mp_redirect: got v=%b pc=%h expected v=1 pc=00000180", redirect_valid, redirect_pc);
        end
        n_tests++;
        if (bp_update_valid !== 1'b1 || bp_update_pc !== 32'h100 || bp_update_target !== 32'h180 || bp_update_taken !== 1'b1) begin
            n_fail++; $display("FAIL mp_bp_update: got v=%b pc=%h tgt=%h tk=%b expected 1/100/180/1",
                bp_update_valid, bp_update_pc, bp_update_target, bp_update_taken);
        end
        n_tests++;
        if (mispredict_count !== 32'd1 || resolve_count !== 32'd1) begin
            n_fail++; $display("FAIL mp_counts: got res=%0d mis=%0d expected 1/1", resolve_count, mispredict_count);
        end
        flush_cycles = 0;
        for (int i = 0; i < 7; i++) begin
            if (flush_if_id === 1'b1 && flush_id_ex === 1'b1) flush_cycles++;
            if (i < 6) step();
        end
        n_tests++;
        if (flush_cycles != 3) begin
            n_fail++; $display("FAIL mp_flush_len: got %0d cycles expected 3", flush_cycles);
        end
        n_tests++;
        if (bp_update_valid !== 1'b0 || redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL mp_quiet: got bp=%b rv=%b expected 0/0", bp_update_valid, redirect_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h400, 1'b1, 32'h400);
        step();
        n_tests++;
        if (redirect_valid !== 1'b0 || flush_if_id !== 1'b0 || bp_update_valid !== 1'b1 ||
            bp_update_pc !== 32'h200 || bp_update_target !== 32'h400 || resolve_count !== 32'd1) begin
            n_fail++; $display("FAIL cp_update: got rv=%b fl=%b bp=%b pc=%h tgt=%h res=%0d expected 0/0/1/200/400/1",
                redirect_valid, flush_if_id, bp_update_valid, bp_update_pc, bp_update_target, resolve_count);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h600 + 32'(i * 4), 32'h900, 1'b0, 32'h0);
            step();
            n_tests++;
            if (bp_update_valid !== 1'b1 || bp_update_pc !== 32'h600 + 32'(i * 4) || bp_update_taken !== 1'b0) begin
                n_fail++; $display("FAIL b2b_%0d: got v=%b pc=%h tk=%b expected 1/%h/0",
                    i, bp_update_valid, bp_update_pc, bp_update_taken, 32'h600 + 32'(i * 4));
            end
        end
        clear_ex();
        step();
        n_tests++;
        if (bp_update_valid !== 1'b0 || resolve_count !== 32'd4 || mispredict_count !== 32'd0 || flush_if_id !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got bp=%b res=%0d mis=%0d fl=%b expected 0/4/0/0",
                bp_update_valid, resolve_count, mispredict_count, flush_if_id);
        end
    endtask

    task automatic test_stall();
        do_reset();
        redirect_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h300, 32'h500, 1'b1, 32'h500);
        step();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin
            n_fail++; $display("FAIL st_first: got v=%b pc=%h expected 1/00000304", redirect_valid, redirect_pc);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i * 16), 32'h2000, 1'b0, 32'h0);
            step();
            n_tests++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || bp_update_valid !== 1'b0 || flush_id_ex !== 1'b1) begin
                n_fail++; $display("FAIL st_hold_%0d: got v=%b pc=%h bp=%b fl=%b expected 1/304/0/1",
                    i, redirect_valid, redirect_pc, bp_update_valid, flush_id_ex);
            end
        end
        n_tests++;
        if (resolve_count !== 32'd1 || mispredict_count !== 32'd1) begin
            n_fail++; $display("FAIL st_counts: got res=%0d mis=%0d expected 1/1", resolve_count, mispredict_count);
        end
        clear_ex();
        redirect_ready = 1'b1;
        step();
        n_tests++;
        if (redirect_valid !== 1'b0 || flush_if_id !== 1'b1) begin
            n_fail++; $display("FAIL st_accept: got v=%b fl=%b expected 0/1", redirect_valid, flush_if_id);
        end
        step();
        step();
        n_tests++;
        if (flush_if_id !== 1'b0) begin
            n_fail++; $display("FAIL st_idle: got fl=%b expected 0", flush_if_id);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'h10);
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || redirect_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL wrap_pc: got v=%b pc=%h mis=%b expected 1/00000000/0",
                redirect_valid, redirect_pc, redirect_misaligned);
        end
        repeat (4) step();
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h80, 32'h202, 1'b1, 32'h300);
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202 || redirect_misaligned !== 1'b1) begin
            n_fail++; $display("FAIL jalr_mis: got v=%b pc=%h mis=%b expected 1/00000202/1",
                redirect_valid, redirect_pc, redirect_misaligned);
        end
        redirect_ready = 1'b1;
        step();
        n_tests++;
        if (redirect_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL jalr_mis_clear: got %b expected 0", redirect_misaligned);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_drain();
        do_reset();
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 1'b0, 32'h0);
        step();
        clear_ex();
        step();
        n_tests++;
        if (flush_if_id !== 1'b1 || redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_in_drain: got fl=%b v=%b expected 1/0", flush_if_id, redirect_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({redirect_valid, flush_if_id, flush_id_ex, bp_update_valid} !== 4'b0 ||
            redirect_pc !== 32'h0 || mispredict_count !== 32'h0) begin
            n_fail++; $display("FAIL rd_async: got v=%b fl=%b/%b bp=%b pc=%h mis=%0d expected all 0",
                redirect_valid, flush_if_id, flush_id_ex, bp_update_valid, redirect_pc, mispredict_count);
        end
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h60, 1'b1, 32'h60);
        step();
        clear_ex();
        n_tests++;
        if (bp_update_valid !== 1'b1 || flush_if_id !== 1'b0 || resolve_count !== 32'd1) begin
            n_fail++; $display("FAIL rd_idle: got bp=%b fl=%b res=%0d expected 1/0/1",
                bp_update_valid, flush_if_id, resolve_count);
        end
    endtask

    task automatic test_drain0();
        do_reset();
        redirect_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'h180, 1'b0, 32'h0);
        step();
        n_tests++;
        if (d0_redirect_valid !== 1'b1 || d0_flush_if_id !== 1'b1 || d0_redirect_pc !== 32'h180) begin
            n_fail++; $display("FAIL d0_redirect: got v=%b fl=%b pc=%h expected 1/1/180",
                d0_redirect_valid, d0_flush_if_id, d0_redirect_pc);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h700, 32'h740, 1'b1, 32'h740);
        step();
        n_tests++;
        if (d0_redirect_valid !== 1'b0 || d0_flush_if_id !== 1'b0 || d0_bp_update_valid !== 1'b0 || d0_resolve_count !== 32'd1) begin
            n_fail++; $display("FAIL d0_return: got v=%b fl=%b bp=%b res=%0d expected 0/0/0/1",
                d0_redirect_valid, d0_flush_if_id, d0_bp_update_valid, d0_resolve_count);
        end
        step();
        clear_ex();
        n_tests++;
        if (d0_bp_update_valid !== 1'b1 || d0_bp_update_pc !== 32'h700 || d0_resolve_count !== 32'd2) begin
            n_fail++; $display("FAIL d0_first_idle: got bp=%b pc=%h res=%0d expected 1/700/2",
                d0_bp_update_valid, d0_bp_update_pc, d0_resolve_count);
        end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_misaligned();
        test_reset_drain();
        test_drain0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
